// File: rtl/sram_bank_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram_bank_ctrl_pkg
// Brief   : Shared types and defaults for the SRAM bank controller.
// Revision: 1.0
// ============================================================================
package sram_bank_ctrl_pkg;

   localparam int unsigned SRAM_DATA_W = 16;
   localparam int unsigned SRAM_DEPTH  = 32;
   localparam int unsigned SRAM_ADDR_W = $clog2(SRAM_DEPTH);

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SETUP = 3'd1,
      EVAL  = 3'd2,
      CAPT  = 3'd3,
      RESP  = 3'd4
   } state_t;

   typedef struct packed {
      logic                   write;
      logic [SRAM_ADDR_W-1:0] addr_a;
      logic [SRAM_ADDR_W-1:0] addr_b;
      logic [SRAM_DATA_W-1:0] wdata;
   } req_t;

   function automatic logic [15:0] sat_inc16(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_bank_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : sram_bank_ctrl_if
// Brief   : Request/response handshake bundle between datapath and controller.
// Revision: 1.0
// ============================================================================
interface sram_bank_ctrl_if
   import sram_bank_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = SRAM_DATA_W,
   parameter int unsigned ADDR_W = SRAM_ADDR_W
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr_a;
   logic [ADDR_W-1:0] req_addr_b;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [DATA_W-1:0] rsp_data_a;
   logic [DATA_W-1:0] rsp_data_b;
   logic              rsp_err;

   modport master (
      output req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr_a, req_addr_b, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_data_a, rsp_data_b, rsp_err
   );
endinterface
`default_nettype wire

// File: rtl/sram_wl_decode.sv
`default_nettype none
// ============================================================================
// Module  : sram_wl_decode
// Brief   : Address to one-hot wordline decode; out-of-range gives all-zero.
// Revision: 1.0
// ============================================================================
module sram_wl_decode #(
   parameter int unsigned ADDR_W = 5,
   parameter int unsigned DEPTH  = 32
) (
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DEPTH-1:0]  o_wl,
   output logic              o_in_range
);

   assign o_in_range = (32'(i_addr) < DEPTH);

   generate
      for (genvar gi = 0; gi < DEPTH; gi++) begin : g_wl
         assign o_wl[gi] = o_in_range && (i_addr == ADDR_W'(gi));
      end
   endgenerate

endmodule
`default_nettype wire

// File: rtl/sram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sram_bank_ctrl
// Brief   : Sequencer for the 2-port SRAM bank. Optional macro
//           SRAM_BANK_CTRL_PERF_EN adds saturating read/write counters.
// Revision: 1.0
// ============================================================================
module sram_bank_ctrl
   import sram_bank_ctrl_pkg::*;
#(
   parameter int unsigned DATA_W = SRAM_DATA_W,
   parameter int unsigned DEPTH  = SRAM_DEPTH,
   parameter int unsigned ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rst_n,
   sram_bank_ctrl_if.slave   bus,
   output logic [DEPTH-1:0]  o_word_a,
   output logic [DEPTH-1:0]  o_word_b,
   output logic              o_read_en,
   output logic              o_write_en,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_srclkneg,
   output logic              o_srclkpos,
   input  logic [DATA_W-1:0] i_out_a,
   input  logic [DATA_W-1:0] i_out_b,
   output logic [15:0]       o_perf_rd_cnt,
   output logic [15:0]       o_perf_wr_cnt
);

   state_t            r_state, w_next;
   req_t              r_req, w_in_req, w_op;
   logic              w_accept, w_rsp_hs;
   logic [DEPTH-1:0]  w_dec_a, w_dec_b;
   logic              w_rng_a, w_rng_b;

   logic              r_req_ready, r_rsp_valid, r_rsp_err;
   logic [DATA_W-1:0] r_rsp_a, r_rsp_b;
   logic [DEPTH-1:0]  r_word_a, r_word_b;
   logic              r_read_en, r_write_en, r_srclkneg, r_srclkpos;
   logic [DATA_W-1:0] r_wdata;

   logic [DEPTH-1:0]  w_word_a_nxt, w_word_b_nxt;
   logic              w_read_en_nxt, w_write_en_nxt, w_srclkneg_nxt, w_srclkpos_nxt;
   logic              w_req_ready_nxt, w_rsp_valid_nxt;
   logic [DATA_W-1:0] w_wdata_nxt;

   assign w_in_req = '{write:  bus.req_write,
                       addr_a: bus.req_addr_a,
                       addr_b: bus.req_addr_b,
                       wdata:  bus.req_wdata};
   assign w_accept = bus.req_valid && r_req_ready;
   assign w_rsp_hs = r_rsp_valid && bus.rsp_ready;

   // Outputs are registered from the next state, so in IDLE the decode must
   // see the incoming request rather than the (stale) latched one.
   assign w_op = (r_state == IDLE) ? w_in_req : r_req;

   sram_wl_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_a (
      .i_addr     (w_op.addr_a),
      .o_wl       (w_dec_a),
      .o_in_range (w_rng_a)
   );

   sram_wl_decode #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) u_dec_b (
      .i_addr     (w_op.addr_b),
      .o_wl       (w_dec_b),
      .o_in_range (w_rng_b)
   );

   always_comb begin
      w_next          = r_state;
      w_word_a_nxt    = '0;
      w_word_b_nxt    = '0;
      w_read_en_nxt   = 1'b0;
      w_write_en_nxt  = 1'b0;
      w_wdata_nxt     = '0;
      w_srclkneg_nxt  = 1'b0;
      w_srclkpos_nxt  = 1'b0;
      w_req_ready_nxt = 1'b0;
      w_rsp_valid_nxt = 1'b0;

      case (r_state)
         IDLE:    if (w_accept) w_next = SETUP;
         SETUP:   w_next = EVAL;
         EVAL:    w_next = CAPT;
         CAPT:    w_next = RESP;
         RESP:    if (w_rsp_hs) w_next = IDLE;
         default: w_next = IDLE;
      endcase

      case (w_next)
         SETUP, EVAL: begin
            w_word_a_nxt   = w_dec_a;
            w_word_b_nxt   = w_dec_b;
            w_read_en_nxt  = ~w_op.write;
            w_write_en_nxt = w_op.write;
            w_wdata_nxt    = w_op.wdata;
            w_srclkneg_nxt = (w_next == SETUP);
            w_srclkpos_nxt = (w_next == EVAL);
         end
         CAPT: begin
            w_word_a_nxt = w_dec_a;
            w_word_b_nxt = w_dec_b;
         end
         RESP:    w_rsp_valid_nxt = 1'b1;
         default: w_req_ready_nxt = 1'b1;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_req       <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_a     <= '0;
         r_rsp_b     <= '0;
         r_word_a    <= '0;
         r_word_b    <= '0;
         r_read_en   <= 1'b0;
         r_write_en  <= 1'b0;
         r_wdata     <= '0;
         r_srclkneg  <= 1'b0;
         r_srclkpos  <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_req_ready <= w_req_ready_nxt;
         r_rsp_valid <= w_rsp_valid_nxt;
         r_word_a    <= w_word_a_nxt;
         r_word_b    <= w_word_b_nxt;
         r_read_en   <= w_read_en_nxt;
         r_write_en  <= w_write_en_nxt;
         r_wdata     <= w_wdata_nxt;
         r_srclkneg  <= w_srclkneg_nxt;
         r_srclkpos  <= w_srclkpos_nxt;
         if (w_accept) begin
            r_req <= w_in_req;
         end
         if (r_state == CAPT) begin
            r_rsp_a   <= r_req.write ? '0 : i_out_a;
            r_rsp_b   <= r_req.write ? '0 : i_out_b;
            r_rsp_err <= ~w_rng_a | ~w_rng_b |
                         (r_req.write & ((r_req.addr_a == '0) | (r_req.addr_b == '0)));
         end
      end
   end

   assign bus.req_ready  = r_req_ready;
   assign bus.rsp_valid  = r_rsp_valid;
   assign bus.rsp_data_a = r_rsp_a;
   assign bus.rsp_data_b = r_rsp_b;
   assign bus.rsp_err    = r_rsp_err;
   assign o_word_a       = r_word_a;
   assign o_word_b       = r_word_b;
   assign o_read_en      = r_read_en;
   assign o_write_en     = r_write_en;
   assign o_wdata        = r_wdata;
   assign o_srclkneg     = r_srclkneg;
   assign o_srclkpos     = r_srclkpos;

`ifdef SRAM_BANK_CTRL_PERF_EN
   logic [15:0] r_perf_rd, r_perf_wr;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_rd <= '0;
         r_perf_wr <= '0;
      end else if (w_rsp_hs) begin
         if (r_req.write) r_perf_wr <= sat_inc16(r_perf_wr);
         else             r_perf_rd <= sat_inc16(r_perf_rd);
      end
   end

   assign o_perf_rd_cnt = r_perf_rd;
   assign o_perf_wr_cnt = r_perf_wr;
`else
   assign o_perf_rd_cnt = '0;
   assign o_perf_wr_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_bank_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram_bank_ctrl
// Brief   : Randomized self-checking bench with array model and reference memory.
// Revision: 1.0
// ============================================================================
module tb_sram_bank_ctrl;

   localparam int DW = 16;
   localparam int DP = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   sram_bank_ctrl_if #(.DATA_W(DW), .ADDR_W(AW)) bus();

   logic [DP-1:0] word_a, word_b;
   logic          read_en, write_en, srclkneg, srclkpos;
   logic [DW-1:0] wdata;
   logic [DW-1:0] out_a = '0;
   logic [DW-1:0] out_b = '0;
   logic [15:0]   perf_rd, perf_wr;

   sram_bank_ctrl #(.DATA_W(DW), .DEPTH(DP), .ADDR_W(AW)) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .bus           (bus.slave),
      .o_word_a      (word_a),
      .o_word_b      (word_b),
      .o_read_en     (read_en),
      .o_write_en    (write_en),
      .o_wdata       (wdata),
      .o_srclkneg    (srclkneg),
      .o_srclkpos    (srclkpos),
      .i_out_a       (out_a),
      .i_out_b       (out_b),
      .o_perf_rd_cnt (perf_rd),
      .o_perf_wr_cnt (perf_wr)
   );

   int n_checks = 0;
   int n_errors = 0;

   task automatic check_value(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Array model: location 0 never stores, reads of it return 0.
   logic [DW-1:0] arr [DP] = '{default: '0};

   function automatic logic [DW-1:0] arr_rd(input logic [DP-1:0] wl);
      logic [DW-1:0] v;
      v = '0;
      for (int i = 1; i < DP; i++) if (wl[i]) v = arr[i];
      return v;
   endfunction

   always @(posedge clk) begin
      if (srclkpos && write_en)
         for (int i = 1; i < DP; i++) if (word_a[i] || word_b[i]) arr[i] <= wdata;
      if (srclkpos && read_en) begin
         out_a <= arr_rd(word_a);
         out_b <= arr_rd(word_b);
      end
   end

   always @(negedge clk) check_value("phase_overlap", 32'(srclkneg & srclkpos), 32'd0);

   // Reference model
   logic [DW-1:0] ref_mem [DP] = '{default: '0};
   int exp_rd = 0;
   int exp_wr = 0;

   function automatic logic [15:0] exp_cnt(input int n);
`ifdef SRAM_BANK_CTRL_PERF_EN
      return (n > 65535) ? 16'hFFFF : 16'(n);
`else
      return (n < 0) ? 16'h1 : 16'h0;
`endif
   endfunction

   task automatic do_op(input logic wr, input logic [AW-1:0] a, input logic [AW-1:0] b,
                        input logic [DW-1:0] d, input int stall, input bit junk);
      logic [DW-1:0] ea, eb;
      logic          ee;
      logic [DP-1:0] wla, wlb;
      int            t;
      ea  = (wr || a == 0) ? '0 : ref_mem[a];
      eb  = (wr || b == 0) ? '0 : ref_mem[b];
      ee  = wr && (a == 0 || b == 0);
      wla = '0; wla[a] = 1'b1;
      wlb = '0; wlb[b] = 1'b1;
      if (wr) begin
         if (a != 0) ref_mem[a] = d;
         if (b != 0) ref_mem[b] = d;
      end

      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = wr;
      bus.req_addr_a = a;
      bus.req_addr_b = b;
      bus.req_wdata  = d;
      t = 0;
      while (!bus.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check_value("req_ready_wait", 32'(bus.req_ready), 32'd1);

      @(negedge clk);
      if (junk) begin
         bus.req_valid  = 1'b1;
         bus.req_write  = 1'($urandom);
         bus.req_addr_a = AW'($urandom);
         bus.req_addr_b = AW'($urandom);
         bus.req_wdata  = DW'($urandom);
      end else begin
         bus.req_valid = 1'b0;
      end
      check_value("setup_srclkneg", 32'(srclkneg), 32'd1);
      check_value("setup_srclkpos", 32'(srclkpos), 32'd0);
      check_value("setup_word_a", word_a, wla);
      check_value("setup_word_b", word_b, wlb);
      check_value("setup_read_en", 32'(read_en), 32'(!wr));
      check_value("setup_write_en", 32'(write_en), 32'(wr));
      if (wr) check_value("setup_wdata", 32'(wdata), 32'(d));

      @(negedge clk);
      check_value("eval_srclkneg", 32'(srclkneg), 32'd0);
      check_value("eval_srclkpos", 32'(srclkpos), 32'd1);
      check_value("eval_word_a", word_a, wla);
      check_value("eval_write_en", 32'(write_en), 32'(wr));

      @(negedge clk);
      check_value("capt_srclkpos", 32'(srclkpos), 32'd0);
      check_value("capt_enables", 32'({read_en, write_en}), 32'd0);
      check_value("capt_word_b", word_b, wlb);
      check_value("capt_rsp_valid", 32'(bus.rsp_valid), 32'd0);

      @(negedge clk);
      check_value("resp_valid", 32'(bus.rsp_valid), 32'd1);
      check_value("resp_word_a", word_a, 32'd0);
      check_value("resp_req_ready", 32'(bus.req_ready), 32'd0);
      check_value("rsp_data_a", 32'(bus.rsp_data_a), 32'(ea));
      check_value("rsp_data_b", 32'(bus.rsp_data_b), 32'(eb));
      check_value("rsp_err", 32'(bus.rsp_err), 32'(ee));

      for (int s = 0; s < stall; s++) begin
         @(negedge clk);
         check_value("stall_valid", 32'(bus.rsp_valid), 32'd1);
         check_value("stall_req_ready", 32'(bus.req_ready), 32'd0);
         check_value("stall_data_a", 32'(bus.rsp_data_a), 32'(ea));
         check_value("stall_err", 32'(bus.rsp_err), 32'(ee));
      end

      bus.rsp_ready = 1'b1;
      bus.req_valid = 1'b0;
      @(negedge clk);
      bus.rsp_ready = 1'b0;
      if (wr) exp_wr++; else exp_rd++;
      check_value("post_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_value("post_req_ready", 32'(bus.req_ready), 32'd1);
      check_value("perf_rd", 32'(perf_rd), 32'(exp_cnt(exp_rd)));
      check_value("perf_wr", 32'(perf_wr), 32'(exp_cnt(exp_wr)));
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int seen;
      logic wr;
      logic [AW-1:0] a, b;
      bus.req_valid  = 1'b0;
      bus.req_write  = 1'b0;
      bus.req_addr_a = '0;
      bus.req_addr_b = '0;
      bus.req_wdata  = '0;
      bus.rsp_ready  = 1'b0;

      repeat (2) @(negedge clk);
      check_value("rst_req_ready", 32'(bus.req_ready), 32'd1);
      check_value("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_value("rst_srclk", 32'({srclkneg, srclkpos}), 32'd0);
      check_value("rst_word_a", word_a, 32'd0);
      check_value("rst_word_b", word_b, 32'd0);
      check_value("rst_enables", 32'({read_en, write_en}), 32'd0);
      check_value("rst_rsp_data", {bus.rsp_data_a, bus.rsp_data_b}, 32'd0);
      check_value("rst_perf", {perf_rd, perf_wr}, 32'd0);
      rst_n = 1'b1;

      do_op(1'b1, 5'd5, 5'd5, 16'hBEEF, 0, 1'b0);
      do_op(1'b0, 5'd5, 5'd0, 16'h0000, 0, 1'b0);
      do_op(1'b1, 5'd0, 5'd7, 16'h1234, 0, 1'b0);
      do_op(1'b0, 5'd7, 5'd0, 16'h0000, 0, 1'b0);
      do_op(1'b0, 5'd5, 5'd7, 16'h0000, 10, 1'b0);

      // Abort a read while it is in EVAL.
      @(negedge clk);
      bus.req_valid  = 1'b1;
      bus.req_write  = 1'b0;
      bus.req_addr_a = 5'd5;
      bus.req_addr_b = 5'd7;
      @(negedge clk);
      bus.req_valid = 1'b0;
      @(negedge clk);
      check_value("abort_in_eval", 32'(srclkpos), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      check_value("abort_srclkpos", 32'(srclkpos), 32'd0);
      check_value("abort_word_a", word_a, 32'd0);
      check_value("abort_read_en", 32'(read_en), 32'd0);
      check_value("abort_rsp_valid", 32'(bus.rsp_valid), 32'd0);
      check_value("abort_req_ready", 32'(bus.req_ready), 32'd1);
      check_value("abort_perf", {perf_rd, perf_wr}, 32'd0);
      exp_rd = 0;
      exp_wr = 0;
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      repeat (8) begin
         @(negedge clk);
         if (bus.rsp_valid) seen++;
      end
      check_value("abort_no_rsp", 32'(seen), 32'd0);
      check_value("abort_ready_after", 32'(bus.req_ready), 32'd1);

      do_op(1'b0, 5'd5, 5'd7, 16'h0, 0, 1'b0);
      do_op(1'b1, 5'd9, 5'd10, 16'hA5A5, 1, 1'b0);
      do_op(1'b0, 5'd9, 5'd10, 16'h0, 0, 1'b0);
      do_op(1'b1, 5'd31, 5'd31, 16'h5A5A, 2, 1'b0);
      do_op(1'b0, 5'd31, 5'd5, 16'h0, 0, 1'b0);
      check_value("perf_3rd", 32'(perf_rd), 32'(exp_cnt(3)));
      check_value("perf_2wr", 32'(perf_wr), 32'(exp_cnt(2)));

      for (int n = 0; n < 40; n++) begin
         wr = 1'($urandom);
         a  = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         b  = ($urandom % 4 == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
         do_op(wr, a, b, DW'($urandom), int'($urandom_range(0, 3)), 1'($urandom));
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
